phase_controller: RTL and testbench

PHASE_CONTROLLER -- requirements
Module: phase_controller

---
 rtl/phase_controller_if.sv | 23 ++
 rtl/phase_controller.sv | 113 +++++++++++
 tb/tb_phase_controller.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/phase_controller_if.sv
// Signal bundle between the phase controller and its environment: the tick
// strobe, per-approach green requests, and the registered lamp/phase outputs.
interface phase_controller_if;
  logic       tick;
  logic [7:0] TGn, TGe, TGs, TGw;
  logic [1:0] next_road;
  logic [1:0] cur_road;
  logic [2:0] light_n, light_e, light_s, light_w;
  logic [7:0] remaining;
  logic       phase_start;

  modport master (
    output tick, TGn, TGe, TGs, TGw,
    input  next_road, cur_road, light_n, light_e, light_s, light_w,
           remaining, phase_start
  );

  modport slave (
    input  tick, TGn, TGe, TGs, TGw,
    output next_road, cur_road, light_n, light_e, light_s, light_w,
           remaining, phase_start
  );
endinterface

// File: rtl/phase_controller.sv
// Round-robin four-approach signal controller: ALLRED -> GREEN -> YELLOW,
// countdowns advancing on the tick strobe, green time clamped to [MIN_G, MAX_G].
module phase_controller #(
  parameter int T_Y   = 3,
  parameter int T_AR  = 1,
  parameter int MIN_G = 5,
  parameter int MAX_G = 60
) (
  input  logic             clk,
  input  logic             reset,
  phase_controller_if.slave bus
);
  typedef enum logic [1:0] {ALLRED = 2'd0, GREEN = 2'd1, YELLOW = 2'd2} state_t;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  state_t           state, state_d;
  logic [7:0]       rem_q, rem_d;
  logic [1:0]       cur_q, cur_d;
  logic [1:0]       nxt_q, nxt_d;
  logic             ps_q, ps_d;
  logic [3:0][2:0]  lamp_q, lamp_d;
  logic [7:0]       tg_sel, tg_clamped;

  // Green time is taken for the road about to be served, i.e. the current next_road.
  always_comb begin
    tg_sel = bus.TGn;
    case (nxt_q)
      2'd0: tg_sel = bus.TGn;
      2'd1: tg_sel = bus.TGe;
      2'd2: tg_sel = bus.TGs;
      2'd3: tg_sel = bus.TGw;
      default: tg_sel = bus.TGn;
    endcase
    if (tg_sel < 8'(MIN_G))      tg_clamped = 8'(MIN_G);
    else if (tg_sel > 8'(MAX_G)) tg_clamped = 8'(MAX_G);
    else                         tg_clamped = tg_sel;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ALLRED;
      rem_q  <= 8'(T_AR);
      cur_q  <= 2'd3;
      nxt_q  <= 2'd0;
      ps_q   <= 1'b0;
      lamp_q <= {4{LAMP_R}};
    end else begin
      state  <= state_d;
      rem_q  <= rem_d;
      cur_q  <= cur_d;
      nxt_q  <= nxt_d;
      ps_q   <= ps_d;
      lamp_q <= lamp_d;
    end
  end

  always_comb begin
    state_d = state;
    rem_d   = rem_q;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    ps_d    = 1'b0;
    if (bus.tick) begin
      if (rem_q <= 8'd1) begin
        case (state)
          ALLRED: begin
            state_d = GREEN;
            cur_d   = nxt_q;
            nxt_d   = nxt_q + 2'd1;
            rem_d   = tg_clamped;
            ps_d    = 1'b1;
          end
          GREEN: begin
            state_d = YELLOW;
            rem_d   = 8'(T_Y);
          end
          YELLOW: begin
            state_d = ALLRED;
            rem_d   = 8'(T_AR);
          end
          default: begin
            state_d = ALLRED;
            rem_d   = 8'(T_AR);
          end
        endcase
      end else begin
        rem_d = rem_q - 8'd1;
      end
    end
  end

  // Lamps are decoded from the next state so they register in step with it.
  always_comb begin
    lamp_d = {4{LAMP_R}};
    case (state_d)
      GREEN:   lamp_d[cur_d] = LAMP_G;
      YELLOW:  lamp_d[cur_d] = LAMP_Y;
      default: lamp_d = {4{LAMP_R}};
    endcase
  end

  assign bus.remaining   = rem_q;
  assign bus.cur_road    = cur_q;
  assign bus.next_road   = nxt_q;
  assign bus.phase_start = ps_q;
  assign bus.light_n     = lamp_q[0];
  assign bus.light_e     = lamp_q[1];
  assign bus.light_s     = lamp_q[2];
  assign bus.light_w     = lamp_q[3];
endmodule

// File: tb/tb_phase_controller.sv
// Directed bench for phase_controller with default timing parameters.
module tb_phase_controller;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  phase_controller_if pif ();
  phase_controller dut (.clk(clk), .reset(reset), .bus(pif.slave));

  always #5 clk = ~clk;

  localparam logic [11:0] ALL_RED = {3'b100, 3'b100, 3'b100, 3'b100};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] lamps();
    return {pif.light_n, pif.light_e, pif.light_s, pif.light_w};
  endfunction

  function automatic logic [2:0] lamp_of(input int road);
    case (road)
      0: return pif.light_n;
      1: return pif.light_e;
      2: return pif.light_s;
      default: return pif.light_w;
    endcase
  endfunction

  task automatic do_tick();
    @(negedge clk) pif.tick = 1'b1;
    @(negedge clk) pif.tick = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Ticks until the given road's lamp leaves the given code; bounded.
  task automatic count_phase(input int road, input logic [2:0] code, output int n);
    n = 0;
    do begin
      do_tick();
      n++;
    end while (lamp_of(road) == code && n < 300);
  endtask

  int  n;
  bit  ps_seen;

  initial begin
    pif.tick = 1'b0;
    pif.TGn = 8'd10; pif.TGe = 8'd0; pif.TGs = 8'd200; pif.TGw = 8'd8;
    reset = 1'b1;
    idle(3);
    @(negedge clk) reset = 1'b0;

    check("rst_remaining", pif.remaining, 1);
    check("rst_cur_road", pif.cur_road, 3);
    check("rst_next_road", pif.next_road, 0);
    check("rst_phase_start", pif.phase_start, 0);
    check("rst_lamps", lamps(), ALL_RED);

    // First green after reset is North
    do_tick();
    check("n_cur_road", pif.cur_road, 0);
    check("n_lamps", lamps(), {3'b001, 3'b100, 3'b100, 3'b100});
    check("n_remaining", pif.remaining, 10);
    check("n_phase_start", pif.phase_start, 1);
    check("n_next_road", pif.next_road, 1);
    idle(1);
    check("n_phase_start_clear", pif.phase_start, 0);

    // Change TGn on the 4th green tick; running green must keep its 10
    repeat (3) do_tick();
    check("n_rem_after3", pif.remaining, 7);
    pif.TGn = 8'd30;
    do_tick();
    check("n_rem_after4", pif.remaining, 6);

    ps_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pif.phase_start) ps_seen = 1;
    end
    check("hold_remaining", pif.remaining, 6);
    check("hold_lamps", lamps(), {3'b001, 3'b100, 3'b100, 3'b100});
    check("hold_phase_start", ps_seen, 0);

    repeat (5) do_tick();
    check("n_rem_9ticks", pif.remaining, 1);
    check("n_still_green", pif.light_n, 3'b001);
    do_tick();
    check("n_yellow", lamps(), {3'b010, 3'b100, 3'b100, 3'b100});
    check("n_yellow_rem", pif.remaining, 3);
    repeat (3) do_tick();
    check("n_allred", lamps(), ALL_RED);
    check("n_allred_rem", pif.remaining, 1);

    // East: TG=0 clamps to MIN_G
    do_tick();
    check("e_remaining", pif.remaining, 5);
    check("e_cur_road", pif.cur_road, 1);
    count_phase(1, 3'b001, n);
    check("e_green_ticks", n, 5);
    count_phase(1, 3'b010, n);
    check("e_yellow_ticks", n, 3);
    do_tick();

    // South: TG=200 clamps to MAX_G
    check("s_remaining", pif.remaining, 60);
    check("s_lamps", lamps(), {3'b100, 3'b100, 3'b001, 3'b100});
    count_phase(2, 3'b001, n);
    check("s_green_ticks", n, 60);
    count_phase(2, 3'b010, n);
    check("s_yellow_ticks", n, 3);
    do_tick();

    // West: next_road wraps to North
    pif.TGn = 8'd8;
    check("w_cur_road", pif.cur_road, 3);
    check("w_next_wrap", pif.next_road, 0);
    check("w_remaining", pif.remaining, 8);
    count_phase(3, 3'b001, n);
    check("w_green_ticks", n, 8);
    count_phase(3, 3'b010, n);
    check("w_yellow_ticks", n, 3);
    check("w_allred", lamps(), ALL_RED);
    do_tick();
    check("n2_cur_road", pif.cur_road, 0);
    check("n2_next_road", pif.next_road, 1);
    check("n2_remaining", pif.remaining, 8);

    // Reset mid-green, coincident with a tick: straight to all red
    repeat (2) do_tick();
    @(negedge clk) begin reset = 1'b1; pif.tick = 1'b1; end
    @(negedge clk) begin reset = 1'b0; pif.tick = 1'b0; end
    check("rg_lamps", lamps(), ALL_RED);
    check("rg_remaining", pif.remaining, 1);
    check("rg_cur_road", pif.cur_road, 3);

    // Reset coincident with terminal yellow tick
    do_tick();
    check("ry_green_n", pif.light_n, 3'b001);
    repeat (8) do_tick();
    check("ry_yellow", pif.light_n, 3'b010);
    repeat (2) do_tick();
    check("ry_yellow_rem", pif.remaining, 1);
    @(negedge clk) begin reset = 1'b1; pif.tick = 1'b1; end
    @(negedge clk) begin reset = 1'b0; pif.tick = 1'b0; end
    check("ry_lamps", lamps(), ALL_RED);
    check("ry_remaining", pif.remaining, 1);
    check("ry_next_road", pif.next_road, 0);
    check("ry_phase_start", pif.phase_start, 0);
    idle(2);
    check("ry_no_green", lamps(), ALL_RED);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
